btn_event_repeater: RTL and testbench



---
 rtl/btn_event_repeater.sv | 113 +++++++++++
 tb/tb_btn_event_repeater.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/btn_event_repeater.sv
// Purpose: turns a debounced button level into press/release/auto-repeat pulses plus a long-press level.
// Latency: every output is registered, one cycle after the edge that samples the causing input.
// Backpressure: none; pulses are single-cycle and must be consumed on arrival.
module btn_event_repeater #(
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned LONG_CYCLES   = 200_000_000,
    parameter int unsigned CNT_W         = 28
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_stable,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic step_pulse,
    output logic long_press,
    output logic held
);

    localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HOLD = 2'd1,
        REPEAT    = 2'd2
    } state_t;

    state_t           state;
    logic             btn_q;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] long_cnt;
    logic [CNT_W-1:0] rep_nxt;
    logic [CNT_W-1:0] rep_tgt;
    logic [CNT_W-1:0] long_nxt;
    logic             press_edge;
    logic             release_edge;

    assign press_edge   = btn_stable & ~btn_q;
    assign release_edge = ~btn_stable & btn_q;

    always_comb begin
        rep_nxt  = rep_cnt + ONE;
        rep_tgt  = (state == WAIT_HOLD) ? HOLD_C : REPEAT_C;
        // Long counter saturates at its threshold so long_press can never drop while held.
        long_nxt = (long_cnt == LONG_C) ? long_cnt : long_cnt + ONE;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            btn_q         <= 1'b0;
            rep_cnt       <= '0;
            long_cnt      <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            step_pulse    <= 1'b0;
            long_press    <= 1'b0;
            held          <= 1'b0;
        end else begin
            btn_q         <= btn_stable;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            step_pulse    <= 1'b0;
            case (state)
                IDLE: begin
                    if (press_edge) begin
                        press_pulse <= 1'b1;
                        step_pulse  <= 1'b1;
                        held        <= 1'b1;
                        long_press  <= 1'b0;
                        rep_cnt     <= '0;
                        long_cnt    <= '0;
                        state       <= WAIT_HOLD;
                    end
                end
                WAIT_HOLD, REPEAT: begin
                    // Release outranks any threshold landing on the same edge.
                    if (release_edge) begin
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        long_press    <= 1'b0;
                        rep_cnt       <= '0;
                        long_cnt      <= '0;
                        state         <= IDLE;
                    end else begin
                        long_cnt <= long_nxt;
                        if (long_nxt == LONG_C) begin
                            long_press <= 1'b1;
                        end
                        if (rep_nxt == rep_tgt) begin
                            repeat_pulse <= 1'b1;
                            step_pulse   <= 1'b1;
                            rep_cnt      <= '0;
                            state        <= REPEAT;
                        end else begin
                            rep_cnt <= rep_nxt;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event_repeater.sv
// Directed bench for btn_event_repeater with HOLD=8, REPEAT=4, LONG=20; expected output
// vectors {press, release, repeat, step, long, held} are queued per cycle and popped at compare.
module tb_btn_event_repeater;

    logic Clk;
    logic Reset;
    logic btn_stable;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;
    logic step_pulse;
    logic long_press;
    logic held;

    int checks = 0;
    int errors = 0;
    int step_cnt;

    logic [5:0] sb[$];

    btn_event_repeater #(
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .LONG_CYCLES  (20),
        .CNT_W        (8)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .btn_stable   (btn_stable),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .step_pulse   (step_pulse),
        .long_press   (long_press),
        .held         (held)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [5:0] vec(input logic p, input logic r, input logic rp,
                                       input logic lp, input logic h);
        return {p, r, rp, p | rp, lp, h};
    endfunction

    // Expected outputs j cycles after the press was sampled, button still held.
    function automatic logic [5:0] hold_vec(input int j);
        logic rp;
        rp = (j >= 8) && (((j - 8) % 4) == 0);
        return vec(j == 0, 1'b0, rp, j >= 20, 1'b1);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_pop(input string tag, input int j);
        logic [5:0] obs;
        logic [5:0] exp;
        obs = {press_pulse, release_pulse, repeat_pulse, step_pulse, long_press, held};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s j=%0d scoreboard empty observed=%b", tag, j, obs);
        end else begin
            exp = sb.pop_front();
            if (step_pulse === 1'b1) step_cnt++;
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s j=%0d observed=%b expected=%b", tag, j, obs, exp);
            end
        end
    endtask

    task automatic check_zero(input int n, input string tag);
        for (int i = 0; i < n; i++) sb.push_back(6'b0);
        for (int i = 0; i < n; i++) begin
            tick();
            check_pop(tag, i);
        end
    endtask

    // Press sampled at the first edge, held hold_len cycles, release sampled at edge P+hold_len.
    task automatic press_hold(input int hold_len, input string tag);
        btn_stable = 1'b1;
        for (int j = 0; j < hold_len; j++) sb.push_back(hold_vec(j));
        sb.push_back(vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int j = 0; j <= hold_len; j++) begin
            tick();
            check_pop(tag, j);
            if (j == hold_len - 1) btn_stable = 1'b0;
        end
    endtask

    initial begin
        Reset      = 1'b1;
        btn_stable = 1'b0;
        check_zero(2, "reset");
        Reset = 1'b0;
        check_zero(2, "idle");

        // Long hold: repeats at 8,12,...,28, long_press from 20, 7 steps.
        step_cnt = 0;
        press_hold(30, "hold30");
        checks++;
        assert (step_cnt === 7) else begin
            errors++;
            $error("FAIL step_count observed=%0d expected=7", step_cnt);
        end
        check_zero(1, "gap1");

        // Short press: release before any repeat.
        press_hold(5, "short5");
        check_zero(8, "after_short");

        // Release coincides with the first-repeat threshold, then re-press at P+10.
        press_hold(8, "rel_at_hold");
        check_zero(1, "gap3");
        press_hold(10, "repress");
        check_zero(2, "gap3b");

        // Button held through reset: press appears the cycle after reset drops.
        Reset      = 1'b1;
        btn_stable = 1'b1;
        check_zero(3, "reset_held");
        Reset = 1'b0;
        press_hold(30, "post_reset");
        check_zero(1, "gap4");

        // Reset sampled at P+14 while repeating: outputs clear, no release pulse.
        btn_stable = 1'b1;
        for (int j = 0; j < 14; j++) sb.push_back(hold_vec(j));
        for (int j = 0; j < 14; j++) begin
            tick();
            check_pop("mid_reset", j);
            if (j == 13) Reset = 1'b1;
        end
        check_zero(1, "in_reset");
        Reset = 1'b0;
        press_hold(3, "after_mid_reset");
        check_zero(1, "gap5");

        // Toggle every cycle: strictly alternating press/release, never a repeat.
        for (int i = 0; i < 10; i++) begin
            if ((i % 2) == 0) sb.push_back(vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
            else              sb.push_back(vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        for (int i = 0; i < 10; i++) begin
            btn_stable = ((i % 2) == 0);
            tick();
            check_pop("toggle", i);
        end
        btn_stable = 1'b0;
        check_zero(3, "final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
